serial_add_sub: RTL and testbench

- Parametrised bit-serial N-bit adder/subtractor; successor to our single-bit combinational adder/subtractor cells.
- Processes one bit pair per clock, LSB first, using one internal full-add/full-subtract slice and a carry/borrow flip-flop.
- Start/done handshake, so datapath blocks can trade latency for area.
- Supports unsigned carry/borrow and signed overflow reporting.

---
 rtl/serial_add_sub_if.sv | 25 ++
 rtl/serial_add_sub.sv | 96 +++++++++
 tb/tb_serial_add_sub.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester uses master; the arithmetic unit uses slave.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial N-bit adder/subtractor: one full-add/full-subtract slice walks
// the operands LSB first, so the cost is WIDTH+2 cycles per operation.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    serial_add_sub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             mode_r;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic ai;
    logic bi;
    logic x;
    logic s;
    logic cy_next;
    logic ovf_bit;
    logic last;

    // On the final bit the slice inputs are the operand MSBs and s is the result MSB.
    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        x       = ai ^ bi;
        s       = x ^ cy;
        cy_next = mode_r ? ((~ai & bi) | (cy & ~x)) : ((ai & bi) | (cy & x));
        ovf_bit = (mode_r ? x : ~x) & (s != ai);
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_sr          <= '0;
            b_sr          <= '0;
            sum_sr        <= '0;
            mode_r        <= 1'b0;
            cy            <= 1'b0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        mode_r   <= bus.mode;
                        cy       <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {s, sum_sr[WIDTH-1:1]};
                    cy     <= cy_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bus.result    <= {s, sum_sr[WIDTH-1:1]};
                        bus.carry_out <= cy_next;
                        bus.overflow  <= ovf_bit;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: stimulus pushes hand-computed results,
// a negedge monitor pops one entry per done pulse.
module tb_serial_add_sub;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_count;
    exp_t sb[$];

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must consume exactly one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", int'(bus.result), int'(e.result));
                checkOutput("carry_out", int'(bus.carry_out), int'(e.carry));
                checkOutput("overflow", int'(bus.overflow), int'(e.ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic m, input logic [WIDTH-1:0] er,
                                 input logic ec, input logic eo);
        exp_t e;
        e.result = er;
        e.carry  = ec;
        e.ovf    = eo;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called #1 after the start edge; optionally scribbles on the inputs during RUN.
    task automatic waitDoneTimed(input string name, input bit disturb);
        int k;
        int busy_cnt;
        k        = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && k < 40) begin
            if (disturb) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF ^ WIDTH'(k);
                bus.b     = ~bus.b;
                bus.mode  = ~bus.mode;
            end
            @(posedge clk);
            #1;
            k++;
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        checkOutput({name, " latency"}, k, WIDTH);
        checkOutput({name, " busy cycles"}, busy_cnt, WIDTH + 1);
        @(posedge clk);
        #1;
        checkOutput({name, " busy after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int dc0;
        int last_pulse;
        int first_pulse;
        int interval_bad;
        int result_bad;

        total      = 0;
        bad        = 0;
        done_count = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset result", int'(bus.result), 0);
        checkOutput("reset carry", int'(bus.carry_out), 0);
        checkOutput("reset overflow", int'(bus.overflow), 0);

        applyStimulus(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        waitDoneTimed("add 35+4A", 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        waitDoneTimed("add FF+01", 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        waitDoneTimed("add 7F+01", 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        waitDoneTimed("add 80+80", 1'b0);
        applyStimulus(8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0);
        waitDoneTimed("sub 05-07", 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
        waitDoneTimed("sub 80-01", 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1);
        waitDoneTimed("sub 7F-FF", 1'b0);

        dc0 = done_count;
        applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        waitDoneTimed("ignore inputs", 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ignore inputs pulses", done_count - dc0, 1);

        // Abort: start edge, two RUN edges, then reset on the third RUN edge.
        dc0 = done_count;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        bus.mode  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy", int'(bus.busy), 0);
        checkOutput("abort done", int'(bus.done), 0);
        checkOutput("abort result", int'(bus.result), 0);
        checkOutput("abort carry", int'(bus.carry_out), 0);
        checkOutput("abort overflow", int'(bus.overflow), 0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort no done", done_count - dc0, 0);
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        waitDoneTimed("add 12+34", 1'b0);

        // Continuous start: pulses expected after cycles 9, 19, 29, 39.
        dc0          = done_count;
        last_pulse   = -1;
        first_pulse  = -1;
        interval_bad = 0;
        result_bad   = 0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.result = 8'h02;
            e.carry  = 1'b0;
            e.ovf    = 1'b0;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.mode  = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (last_pulse >= 0 && cyc - last_pulse != WIDTH + 2) interval_bad++;
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
            end
            if (last_pulse >= 0 && bus.result != 8'h02) result_bad++;
        end
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("stream pulses", done_count - dc0, 4);
        checkOutput("stream first pulse", first_pulse, WIDTH + 1);
        checkOutput("stream interval", interval_bad, 0);
        checkOutput("stream result stable", result_bad, 0);
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
